// File: rtl/bf16_dot_acc_44.sv
// bf16_dot_acc_44: sequences a stream of BF16 products through an external
// BF16 adder, one add in flight at a time, buffering products in a small FIFO.
// The block performs no arithmetic itself; the accumulator only ever loads
// the adder's result.
module bf16_dot_acc_44 #(
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_44,
    input  logic             rst_44,
    input  logic             start_44,
    input  logic [LEN_W-1:0] len_44,
    input  logic [15:0]      prod_44,
    input  logic             prod_valid_44,
    output logic [15:0]      add_a_44,
    output logic [15:0]      add_b_44,
    output logic             add_valid_in_44,
    input  logic [15:0]      add_result_44,
    input  logic             add_valid_out_44,
    output logic [15:0]      acc_44,
    output logic             done_44,
    output logic             busy_44,
    output logic             ovf_44
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [15:0]      mem [FIFO_DEPTH];
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot on the same edge, so a push into a full FIFO is
    // still accepted when a pop accompanies it
    assign pop  = (state == S_RUN) && (len_q != '0) && !fifo_empty;
    assign push = prod_valid_44 && (state != S_IDLE) && (!fifo_full || pop);
    assign drop = prod_valid_44 && (state != S_IDLE) && fifo_full && !pop;

    assign cnt_inc = cnt + 1'b1;

    assign done_44 = (state == S_DONE);
    assign busy_44 = (state != S_IDLE);

    // Product storage; empty is computed from registered pointers, so a new
    // entry is never visible to the pop logic in the cycle it is written
    always_ff @(posedge clk_44) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= prod_44;
        end
    end

    // Control FSM, FIFO pointers and registered adder interface
    always_ff @(posedge clk_44 or posedge rst_44) begin
        if (rst_44) begin
            state           <= S_IDLE;
            len_q           <= '0;
            cnt             <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            acc_44          <= '0;
            add_a_44        <= '0;
            add_b_44        <= '0;
            add_valid_in_44 <= 1'b0;
            ovf_44          <= 1'b0;
        end else begin
            add_valid_in_44 <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                ovf_44 <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start_44) begin
                        acc_44 <= '0;
                        cnt    <= '0;
                        ovf_44 <= 1'b0;
                        len_q  <= len_44;
                        // No push happens in IDLE, so wr_ptr is stable here
                        rd_ptr <= wr_ptr;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (len_q == '0) begin
                        state <= S_DONE;
                    end else if (!fifo_empty) begin
                        add_a_44        <= acc_44;
                        add_b_44        <= mem[rd_ptr[AW-1:0]];
                        add_valid_in_44 <= 1'b1;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (add_valid_out_44) begin
                        acc_44 <= add_result_44;
                        cnt    <= cnt_inc;
                        state  <= (cnt_inc == len_q) ? S_DONE : S_RUN;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_dot_acc_44.sv
// tb_bf16_dot_acc_44: directed vectors with hand-computed BF16 results.
// A small responder stands in for the BF16 adder using a lookup of the sums
// these vectors produce.
module tb_bf16_dot_acc_44;

    logic        clk_44 = 1'b0;
    logic        rst_44 = 1'b0;
    logic        start_44 = 1'b0;
    logic [7:0]  len_44 = '0;
    logic [15:0] prod_44 = '0;
    logic        prod_valid_44 = 1'b0;
    logic [15:0] add_a_44;
    logic [15:0] add_b_44;
    logic        add_valid_in_44;
    logic [15:0] add_result_44 = '0;
    logic        add_valid_out_44 = 1'b0;
    logic [15:0] acc_44;
    logic        done_44;
    logic        busy_44;
    logic        ovf_44;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          adder_en = 1'b1;
    int          adder_lat = 2;
    logic [15:0] req_a[$];
    logic [15:0] req_b[$];

    bf16_dot_acc_44 #(.LEN_W(8), .FIFO_DEPTH(4)) dut (
        .clk_44           (clk_44),
        .rst_44           (rst_44),
        .start_44         (start_44),
        .len_44           (len_44),
        .prod_44          (prod_44),
        .prod_valid_44    (prod_valid_44),
        .add_a_44         (add_a_44),
        .add_b_44         (add_b_44),
        .add_valid_in_44  (add_valid_in_44),
        .add_result_44    (add_result_44),
        .add_valid_out_44 (add_valid_out_44),
        .acc_44           (acc_44),
        .done_44          (done_44),
        .busy_44          (busy_44),
        .ovf_44           (ovf_44)
    );

    always #5 clk_44 = ~clk_44;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_44);
        #1;
    endtask

    // Sums reachable by the vectors below: a + 0.0 and small integers + 1.0
    function automatic logic [15:0] add_lut(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'h0000) return a;
        if (b == 16'h3F80) begin
            case (a)
                16'h0000: return 16'h3F80;
                16'h3F80: return 16'h4000;
                16'h4000: return 16'h4040;
                16'h4040: return 16'h4080;
                16'h4080: return 16'h40A0;
                16'h40A0: return 16'h40C0;
                16'h40C0: return 16'h40E0;
                16'h40E0: return 16'h4100;
                default:  return 16'hDEAD;
            endcase
        end
        return 16'hDEAD;
    endfunction

    task automatic wait_req(input string tag);
        int n = 0;
        while (!add_valid_in_44 && n < 20) begin
            tick();
            n++;
        end
        check(tag, add_valid_in_44, 1);
    endtask

    task automatic wait_done(input string tag, input int budget, input bit chk_busy);
        int n = 0;
        while (!done_44 && n < budget) begin
            if (chk_busy) check({tag, " busy"}, busy_44, 1);
            tick();
            n++;
        end
        check({tag, " done"}, done_44, 1);
        check({tag, " busy at done"}, busy_44, 1);
    endtask

    // Adder stand-in: logs every request and, when enabled, answers after adder_lat edges
    initial begin
        logic [15:0] res;
        forever begin
            @(posedge clk_44);
            #1;
            if (add_valid_in_44) begin
                req_a.push_back(add_a_44);
                req_b.push_back(add_b_44);
                if (adder_en) begin
                    res = add_lut(add_a_44, add_b_44);
                    repeat (adder_lat - 1) begin
                        @(posedge clk_44);
                        #1;
                    end
                    add_result_44    = res;
                    add_valid_out_44 = 1'b1;
                    @(posedge clk_44);
                    #1;
                    add_valid_out_44 = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_a3 [3] = '{16'h0000, 16'h3F80, 16'h4000};
        logic [15:0] ovf_in [6] = '{16'h3F80, 16'h0000, 16'h3F80, 16'h0000, 16'h3F80, 16'h4000};
        logic [15:0] ovf_b  [8] = '{16'h3F80, 16'h0000, 16'h3F80, 16'h0000,
                                    16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};

        // Reset state
        #1 rst_44 = 1'b1;
        #2;
        check("rst acc", acc_44, 16'h0000);
        check("rst add_a", add_a_44, 16'h0000);
        check("rst add_b", add_b_44, 16'h0000);
        check("rst vin", add_valid_in_44, 0);
        check("rst done", done_44, 0);
        check("rst busy", busy_44, 0);
        check("rst ovf", ovf_44, 0);
        repeat (2) tick();
        rst_44 = 1'b0;
        tick();

        // Basic: three times 1.0, adder latency 2
        req_a.delete(); req_b.delete();
        adder_en = 1'b1; adder_lat = 2;
        start_44 = 1'b1; len_44 = 8'd3;
        tick();
        start_44 = 1'b0;
        check("basic busy", busy_44, 1);
        prod_valid_44 = 1'b1; prod_44 = 16'h3F80;
        repeat (3) tick();
        prod_valid_44 = 1'b0;
        wait_done("basic", 60, 1'b0);
        check("basic acc", acc_44, 16'h4040);
        check("basic nreq", req_a.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (req_a.size() > i) begin
                check($sformatf("basic a%0d", i), req_a[i], exp_a3[i]);
                check($sformatf("basic b%0d", i), req_b[i], 16'h3F80);
            end
        end
        tick();
        check("basic done pulse", done_44, 0);
        check("basic idle", busy_44, 0);
        check("basic acc hold", acc_44, 16'h4040);

        // Zero length: done in the second cycle after the start edge, no add
        req_a.delete(); req_b.delete();
        start_44 = 1'b1; len_44 = 8'd0;
        tick();
        start_44 = 1'b0;
        check("zl done early", done_44, 0);
        check("zl acc cleared", acc_44, 16'h0000);
        tick();
        check("zl done", done_44, 1);
        tick();
        check("zl done pulse", done_44, 0);
        check("zl idle", busy_44, 0);
        check("zl no add", req_a.size(), 0);

        // Overflow: adder withheld; p1 is popped, p2..p5 fill the buffer, p6 is dropped
        req_a.delete(); req_b.delete();
        adder_en = 1'b0;
        start_44 = 1'b1; len_44 = 8'd8;
        tick();
        start_44 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            prod_valid_44 = 1'b1; prod_44 = ovf_in[i];
            tick();
            if (i == 4) check("ovf before full", ovf_44, 0);
        end
        prod_valid_44 = 1'b0;
        check("ovf set", ovf_44, 1);
        check("ovf one pop", req_a.size(), 1);
        if (req_a.size() > 0) begin
            check("ovf a0", req_a[0], 16'h0000);
            check("ovf b0", req_b[0], 16'h3F80);
        end
        add_result_44 = 16'h3F80; add_valid_out_44 = 1'b1; adder_en = 1'b1; adder_lat = 2;
        tick();
        add_valid_out_44 = 1'b0;
        repeat (30) tick();
        prod_valid_44 = 1'b1; prod_44 = 16'h3F80;
        repeat (3) tick();
        prod_valid_44 = 1'b0;
        wait_done("ovf", 80, 1'b0);
        check("ovf acc", acc_44, 16'h40C0);
        check("ovf nreq", req_b.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (req_b.size() > i) check($sformatf("ovf b%0d", i), req_b[i], ovf_b[i]);
        end
        check("ovf sticky", ovf_44, 1);
        tick();
        start_44 = 1'b1; len_44 = 8'd0;
        tick();
        start_44 = 1'b0;
        check("ovf cleared", ovf_44, 0);
        repeat (2) tick();

        // Start during WAIT is ignored; original len=2 completes
        req_a.delete(); req_b.delete();
        adder_lat = 3;
        start_44 = 1'b1; len_44 = 8'd2;
        tick();
        start_44 = 1'b0;
        prod_valid_44 = 1'b1; prod_44 = 16'h3F80;
        repeat (2) tick();
        prod_valid_44 = 1'b0;
        check("bs in wait", add_valid_in_44, 1);
        start_44 = 1'b1; len_44 = 8'd5;
        tick();
        start_44 = 1'b0;
        wait_done("bs", 60, 1'b1);
        check("bs acc", acc_44, 16'h4000);
        check("bs nreq", req_a.size(), 2);
        tick();
        check("bs idle", busy_44, 0);
        check("bs done pulse", done_44, 0);

        // Reset asserted between edges while in WAIT with acc = 1.0
        req_a.delete(); req_b.delete();
        adder_en = 1'b0;
        start_44 = 1'b1; len_44 = 8'd2;
        tick();
        start_44 = 1'b0;
        prod_valid_44 = 1'b1; prod_44 = 16'h3F80;
        repeat (2) tick();
        prod_valid_44 = 1'b0;
        wait_req("mr req1");
        add_result_44 = 16'h3F80; add_valid_out_44 = 1'b1;
        tick();
        add_valid_out_44 = 1'b0;
        wait_req("mr req2");
        check("mr add_a", add_a_44, 16'h3F80);
        tick();
        #2 rst_44 = 1'b1;
        #1;
        check("mr acc", acc_44, 16'h0000);
        check("mr add_a rst", add_a_44, 16'h0000);
        check("mr add_b rst", add_b_44, 16'h0000);
        check("mr vin", add_valid_in_44, 0);
        check("mr busy", busy_44, 0);
        check("mr done", done_44, 0);
        check("mr ovf", ovf_44, 0);
        #1 rst_44 = 1'b0;
        add_result_44 = 16'h3F80; add_valid_out_44 = 1'b1;
        tick();
        add_valid_out_44 = 1'b0;
        check("mr late acc", acc_44, 16'h0000);
        check("mr late busy", busy_44, 0);
        tick();
        check("mr still idle", busy_44, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
